// File: rtl/rv32_hart_pc_sched.sv
// Per-hart PC scheduler for the barrel RV32 core: round-robin issue of one hart's
// PC per cycle to fetch, and write-back of the commit-time next PC into that hart.
module rv32_hart_pc_sched #(
  parameter int          NUM_HARTS = 8,
  parameter int          HART_W    = $clog2(NUM_HARTS),
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_HARTS-1:0] hart_en,
  input  logic                 fetch_stall,
  output logic                 fetch_valid,
  output logic [HART_W-1:0]    fetch_hart_id,
  output logic [31:0]          fetch_pc,
  input  logic                 cmt_valid,
  input  logic [HART_W-1:0]    cmt_hart_id,
  input  logic                 cmt_has_new_pc,
  input  logic [31:0]          cmt_next_pc,
  output logic [NUM_HARTS-1:0] hart_busy,
  output logic                 misalign_err,
  output logic                 spurious_cmt
);

  logic [31:0]          pc_q [NUM_HARTS];
  logic [NUM_HARTS-1:0] busy_q;
  logic [HART_W-1:0]    last_id_q;

  logic [NUM_HARTS-1:0] eligible;
  logic [NUM_HARTS-1:0] busy_d;
  logic [HART_W-1:0]    sel_id;
  logic [HART_W-1:0]    idx;
  logic                 found;
  logic                 load;
  logic                 cmt_ok;
  logic [31:0]          cmt_pc;

  // Offer handshake: fetch_valid/fetch_hart_id/fetch_pc form an offer that is
  // consumed on any edge where fetch_stall is low; while fetch_valid=1 and
  // fetch_stall=1 the offer holds stable and no new hart is searched or marked busy.
  assign load = !fetch_valid || !fetch_stall;

  always_comb begin
    eligible = hart_en & ~busy_q;
    found    = 1'b0;
    sel_id   = last_id_q;
    idx      = last_id_q;
    // Search order last_id+1 .. last_id+NUM_HARTS; the id width wraps modulo NUM_HARTS.
    for (int i = 1; i <= NUM_HARTS; i++) begin
      idx = last_id_q + HART_W'(i);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        sel_id = idx;
      end
    end
  end

  assign cmt_ok = cmt_valid && busy_q[cmt_hart_id];
  assign cmt_pc = cmt_has_new_pc ? {cmt_next_pc[31:2], 2'b00}
                                 : pc_q[cmt_hart_id] + 32'd4;

  // Issued hart is never busy and committed hart always is, so the two never collide.
  always_comb begin
    busy_d = busy_q;
    if (load && found) busy_d[sel_id] = 1'b1;
    if (cmt_ok) busy_d[cmt_hart_id] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < NUM_HARTS; h++) pc_q[h] <= RESET_PC;
      busy_q        <= '0;
      last_id_q     <= HART_W'(NUM_HARTS - 1);
      fetch_valid   <= 1'b0;
      fetch_hart_id <= '0;
      fetch_pc      <= '0;
      misalign_err  <= 1'b0;
      spurious_cmt  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (load) begin
        if (found) begin
          fetch_valid   <= 1'b1;
          fetch_hart_id <= sel_id;
          fetch_pc      <= pc_q[sel_id];
          last_id_q     <= sel_id;
        end else begin
          fetch_valid <= 1'b0;
        end
      end
      if (cmt_ok) pc_q[cmt_hart_id] <= cmt_pc;
      misalign_err <= cmt_ok && cmt_has_new_pc && (cmt_next_pc[1:0] != 2'b00);
      spurious_cmt <= cmt_valid && !busy_q[cmt_hart_id];
    end
  end

  assign hart_busy = busy_q;

endmodule

// File: doc/rv32_hart_pc_sched.md
# rv32_hart_pc_sched

Per-hart program-counter scheduler for the barrel RV32 core. It holds one PC per hart and picks the next hart to fetch in round-robin order, offering its PC to the fetch stage. It applies the commit-time PC outcome (taken branch/jump target or sequential PC+4) back into that hart's PC. It sits between the fetch stage and the write-back/commit point, where the next-PC calculation result is known.

## Interface
Parameters:
- NUM_HARTS, 8, number of hardware threads; power of two, ≥2
- HART_W, $clog2(NUM_HARTS), hart-id width
- RESET_PC, 32'h0000_0000, PC loaded into every hart at reset

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- hart_en  in  NUM_HARTS  per-hart run enable; a cleared bit makes that hart ineligible for issue
- fetch_stall  in  1  fetch stage cannot accept the current offer
- fetch_valid  out  1  offer register holds a valid hart/PC
- fetch_hart_id  out  HART_W  hart being offered
- fetch_pc  out  32  PC being offered
- cmt_valid  in  1  one instruction commits this cycle
- cmt_hart_id  in  HART_W  hart of the committing instruction
- cmt_has_new_pc  in  1  1 = redirect to cmt_next_pc; 0 = sequential
- cmt_next_pc  in  32  redirect target
- hart_busy  out  NUM_HARTS  per-hart in-flight flag
- misalign_err  out  1  one-cycle pulse: redirect target had bits[1:0] ≠ 0
- spurious_cmt  out  1  one-cycle pulse: commit for a non-busy hart

## Operation
- State: pc[NUM_HARTS] (32 b each), busy[NUM_HARTS], last_id (HART_W), offer register (fetch_valid/fetch_hart_id/fetch_pc).
- Eligible hart h: hart_en[h]=1 and busy[h]=0, evaluated on register values at the start of the cycle.
- Load condition: fetch_valid=0 or fetch_stall=0.
- On the load condition, search starts at last_id+1 and proceeds modulo NUM_HARTS. The first eligible hart h is loaded into the offer register (fetch_hart_id=h, fetch_pc=pc[h], fetch_valid=1). busy[h] is set and last_id becomes h.
- On the load condition with no eligible hart: fetch_valid is cleared and last_id is unchanged.
- Commit with cmt_valid=1 and busy[cmt_hart_id]=1:
  - pc[id] becomes cmt_has_new_pc ? {cmt_next_pc[31:2],2'b00} : pc[id]+4.
  - The +4 addition wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
  - busy[id] is cleared.
- Misaligned redirect: cmt_has_new_pc=1 with cmt_next_pc[1:0]≠0 pulses misalign_err the next cycle. The target is still applied with bits[1:0] forced to 0.
- Commit with busy[cmt_hart_id]=0: no state change; spurious_cmt pulses the next cycle.
- Same-cycle commit and issue for the same hart: that hart is not eligible in the commit cycle (it is still busy). It can be chosen one cycle later and is offered with the updated PC.
- Clearing hart_en while a hart is busy does not cancel it: its commit is still applied, and it is then not re-issued until re-enabled.
- Only one commit per cycle. The PC of a busy hart is never read for issue.

## Timing
- Reset (asynchronous, any cycle, including mid-stall):
  - all pc = RESET_PC; busy = 0; last_id = NUM_HARTS-1, so hart 0 is issued first
  - fetch_valid = 0, fetch_hart_id = 0, fetch_pc = 0, hart_busy = 0, misalign_err = 0, spurious_cmt = 0
- First offer: fetch_valid rises on the first clock edge after rst deasserts, provided any hart is enabled.
- Issue latency: the offer is visible one cycle after the edge at which the load condition held. With no stall, a new hart is offered every cycle.
- fetch_stall=1 with fetch_valid=1: fetch_valid, fetch_hart_id and fetch_pc hold stable. No search, no busy change.
- Commit latency: pc and busy update at the commit edge. The hart becomes eligible for the search at the following edge, so the minimum commit-to-reoffer time is 2 cycles.
- hart_busy is a direct register output. misalign_err and spurious_cmt are registered single-cycle pulses.

## Test plan
- Reset, hart_en=8'hFF, no stall, no commits → harts 0..7 are offered on 8 consecutive cycles, all with PC 0. fetch_valid then drops (all busy) and hart_busy=8'hFF.
- Hart 3 commits with has_new_pc=0, then hart 5 commits with has_new_pc=1, next_pc=32'h0000_0100 → hart 3 is re-offered with PC 4 and hart 5 with PC 0x100, in round-robin order after last_id.
- fetch_stall held for 3 cycles while hart 2 is offered → outputs are unchanged for 3 cycles. After release, hart 3 follows on the next cycle.
- hart_en=8'b1010_0101 → issue order is 0,2,5,7,0...; disabled harts are never offered.
- Commit with next_pc=32'h0000_0203 → misalign_err pulses once and the hart is re-offered at 0x200. Commit with pc=32'hFFFF_FFFC sequential → PC becomes 0.
- Commit for a hart with busy=0 → spurious_cmt pulses and pc is unchanged. rst asserted mid-stall → all outputs are at reset values immediately, and hart 0 is offered first after release.
